// File: rtl/router_ingress_arb.sv
// Round-robin ingress arbiter feeding the router's single byte-wide input port.
// Grants one source for a whole packet and swallows packets addressed to dest 3.
module router_ingress_arb #(
    parameter int N_SRC      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_din,
    output logic [N_SRC-1:0]   src_ready,
    output logic [N_SRC-1:0]   grant,
    input  logic               busy,
    output logic               pkt_valid,
    output logic [7:0]         din,
    output logic               drop
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAY, S_PAR, S_DRAIN, S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N_SRC-1:0] r_grant;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_pick;
    logic [5:0]       r_len;
    logic [3:0]       r_gap;
    logic             r_occ;
    logic             r_pv;
    logic [7:0]       r_din;
    logic             r_drop;
    logic             w_req_any;
    logic             w_sel_valid;
    logic [7:0]       w_sel_byte;
    logic             w_xfer_ok;
    logic             w_accept;
    logic             w_rdy;
    logic             w_hs;
    logic             w_load;
    logic             w_hdr_drop;

    // First requester strictly after ptr, wrapping; nearest candidate wins.
    function automatic logic [IW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        logic [IW-1:0] cand;
        pick = ptr;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N_SRC);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign w_req_any   = |src_valid;
    assign w_pick      = rr_pick(src_valid, r_ptr);
    assign w_sel_valid = src_valid[r_ptr];
    assign w_sel_byte  = src_din[{r_ptr, 3'b000} +: 8];
    assign w_hdr_drop  = (w_sel_byte[1:0] == 2'b11);
    assign w_accept    = r_occ & ~busy;
    assign w_xfer_ok   = ~r_occ | ~busy;
    assign w_hs        = w_rdy & w_sel_valid;
    assign w_load      = w_hs & (((r_state == S_HDR) & ~w_hdr_drop) |
                                 (r_state == S_PAY) | (r_state == S_PAR));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if ((r_gap == 4'd0) && w_req_any) w_next = S_HDR;
            S_HDR: begin
                if (w_hs) begin
                    if (w_hdr_drop)                 w_next = S_DRAIN;
                    else if (w_sel_byte[7:2] == '0) w_next = S_PAR;
                    else                            w_next = S_PAY;
                end
            end
            S_PAY:   if (w_hs && (r_len == 6'd1)) w_next = S_PAR;
            S_PAR:   if (w_hs) w_next = S_GAP;
            S_DRAIN: if (w_hs && (r_len == 6'd0)) w_next = S_GAP;
            S_GAP:   if (!r_occ && !busy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Dropped packets are sunk at full rate; forwarded ones wait on the output stage.
    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            S_HDR, S_PAY, S_PAR: w_rdy = w_xfer_ok;
            S_DRAIN:             w_rdy = 1'b1;
            default:             w_rdy = 1'b0;
        endcase
        src_ready = w_rdy ? r_grant : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= IW'(N_SRC - 1);
            r_len   <= 6'd0;
            r_gap   <= 4'd0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_gap != 4'd0) begin
                        r_gap <= r_gap - 4'd1;
                    end else if (w_req_any) begin
                        r_grant <= {{(N_SRC-1){1'b0}}, 1'b1} << w_pick;
                        r_ptr   <= w_pick;
                    end
                end
                S_HDR:   if (w_hs) r_len <= w_sel_byte[7:2];
                S_PAY:   if (w_hs && (r_len != 6'd0)) r_len <= r_len - 6'd1;
                S_DRAIN: begin
                    if (w_hs) begin
                        if (r_len == 6'd0) r_drop <= 1'b1;
                        else               r_len  <= r_len - 6'd1;
                    end
                end
                S_GAP: begin
                    if (!r_occ && !busy) begin
                        r_grant <= '0;
                        r_gap   <= 4'(GAP_CYCLES);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: one byte toward the router, emptied when the router takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ <= 1'b0;
            r_din <= 8'h00;
            r_pv  <= 1'b0;
        end else if (w_load) begin
            r_occ <= 1'b1;
            r_din <= w_sel_byte;
            r_pv  <= (r_state != S_PAR);
        end else if (w_accept) begin
            r_occ <= 1'b0;
            r_din <= 8'h00;
            r_pv  <= 1'b0;
        end
    end

    assign grant     = r_grant;
    assign din       = r_din;
    assign pkt_valid = r_pv;
    assign drop      = r_drop;

endmodule

// File: tb/tb_router_ingress_arb.sv
// Directed bench for router_ingress_arb: per-source byte queues feed the DUT,
// and the router-side byte stream is logged for packet-level checks.
module tb_router_ingress_arb;

    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int LOGN = 512;

    logic           clock     = 1'b0;
    logic           reset     = 1'b1;
    logic           busy      = 1'b0;
    logic [N-1:0]   src_valid = '0;
    logic [8*N-1:0] src_din   = '0;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   grant;
    logic           pkt_valid;
    logic [7:0]     din;
    logic           drop;

    always #5 clock = ~clock;

    router_ingress_arb #(.N_SRC(N), .GAP_CYCLES(GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_valid (src_valid),
        .src_din   (src_din),
        .src_ready (src_ready),
        .grant     (grant),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .din       (din),
        .drop      (drop)
    );

    logic [7:0] smem [N][LOGN];
    int         shead [N];
    int         stail [N];
    int         hs_cnt [N];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         drop_cnt = 0;

    logic [7:0]   s_din;
    logic         s_pv;
    logic         s_drop;
    logic [N-1:0] s_grant;
    logic [N-1:0] s_ready;
    logic [N-1:0] s_hs;

    logic [7:0]   lg_din   [LOGN];
    logic         lg_pv    [LOGN];
    logic [N-1:0] lg_grant [LOGN];
    int           lg_cyc   [LOGN];
    int           lg_n = 0;

    logic [7:0] t1_din [9] = '{8'h00, 8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00};
    logic       t1_pv  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] t1_gnt [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [3:0] t1_rdy [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};

    logic [7:0] t2_din [13] = '{8'h05, 8'hA0, 8'hA5, 8'h06, 8'hB0, 8'hB6, 8'h04, 8'hC0, 8'hC4,
                                8'h09, 8'hA1, 8'hA2, 8'h0A};
    logic       t2_pv  [13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b0};

    logic [3:0] t4_gnt  [8] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4};
    logic [3:0] t4_rdy  [8] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};
    logic       t4_drop [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] b);
        smem[s][stail[s]] = b;
        stail[s]++;
    endtask

    // Header, L payload bytes (first, first+step, ...), then XOR parity.
    task automatic push_pkt(input int s, input logic [7:0] hdr,
                            input logic [7:0] first, input logic [7:0] step);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        push(s, hdr);
        for (int k = 0; k < int'(hdr[7:2]); k++) begin
            b = first + 8'(k) * step;
            par ^= b;
            push(s, b);
        end
        push(s, par);
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (shead[i] < stail[i]) e = 1'b0;
        return e;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < N; i++) shead[i] = stail[i];
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_valid[i]     = (shead[i] < stail[i]);
            src_din[8*i +: 8] = src_valid[i] ? smem[i][shead[i]] : 8'h00;
        end
    endtask

    // One clock: drive sources, sample mid-cycle, then retire handshaken bytes.
    task automatic cycle();
        drive();
        @(negedge clock);
        cyc++;
        s_din   = din;
        s_pv    = pkt_valid;
        s_grant = grant;
        s_ready = src_ready;
        s_drop  = drop;
        s_hs    = src_valid & src_ready;
        for (int i = 0; i < N; i++) if (s_hs[i]) hs_cnt[i]++;
        if (drop) drop_cnt++;
        if (!busy && !reset && (pkt_valid || din != 8'h00) && lg_n < LOGN) begin
            lg_din[lg_n]   = din;
            lg_pv[lg_n]    = pkt_valid;
            lg_grant[lg_n] = grant;
            lg_cyc[lg_n]   = cyc;
            lg_n++;
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (s_hs[i] && shead[i] < stail[i]) shead[i]++;
    endtask

    task automatic wait_quiet(input string tag);
        int q;
        q = 0;
        for (int t = 0; t < 400 && q < 4; t++) begin
            cycle();
            if (all_empty() && s_grant == '0) q++;
            else q = 0;
        end
        check_eq(tag, 32'(q >= 4), 32'd1);
    endtask

    task automatic check_log(input string tag, input int idx,
                             input logic [7:0] exp_din, input logic exp_pv);
        check_eq($sformatf("%s_din", tag), 32'(lg_din[idx]), 32'(exp_din));
        check_eq($sformatf("%s_pv", tag), 32'(lg_pv[idx]), 32'(exp_pv));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int h0;
        int d0;
        int bad;
        bit found;

        for (int i = 0; i < N; i++) begin
            shead[i] = 0; stail[i] = 0; hs_cnt[i] = 0;
        end

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        check_eq("rst_grant", 32'(s_grant), 32'd0);
        check_eq("rst_ready", 32'(s_ready), 32'd0);
        check_eq("rst_pv", 32'(s_pv), 32'd0);
        check_eq("rst_din", 32'(s_din), 32'd0);
        check_eq("rst_drop", 32'(s_drop), 32'd0);
        reset = 1'b0;

        // Single source, dest 1, L=3, cycle by cycle
        push_pkt(0, 8'h0D, 8'h11, 8'h11);
        for (int c = 0; c < 9; c++) begin
            cycle();
            check_eq($sformatf("t1_din[%0d]", c), 32'(s_din), 32'(t1_din[c]));
            check_eq($sformatf("t1_pv[%0d]", c), 32'(s_pv), 32'(t1_pv[c]));
            check_eq($sformatf("t1_gnt[%0d]", c), 32'(s_grant), 32'(t1_gnt[c]));
            check_eq($sformatf("t1_rdy[%0d]", c), 32'(s_ready), 32'(t1_rdy[c]));
        end
        wait_quiet("t1_quiet");

        // Router busy for 3 cycles while payload 22 sits on din
        base = lg_n;
        push_pkt(0, 8'h0D, 8'h11, 8'h11);
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            cycle();
            if (s_din == 8'h11 && s_pv) found = 1'b1;
        end
        check_eq("t3_sync", 32'(found), 32'd1);
        busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_eq($sformatf("t3_hold_din[%0d]", c), 32'(s_din), 32'h22);
            check_eq($sformatf("t3_hold_pv[%0d]", c), 32'(s_pv), 32'd1);
            check_eq($sformatf("t3_hold_rdy[%0d]", c), 32'(s_ready), 32'd0);
        end
        busy = 1'b0;
        cycle();
        check_eq("t3_rel_din", 32'(s_din), 32'h22);
        check_eq("t3_rel_rdy", 32'(s_ready), 32'h1);
        cycle();
        check_eq("t3_next_din", 32'(s_din), 32'h33);
        wait_quiet("t3_quiet");
        check_eq("t3_count", 32'(lg_n - base), 32'd5);
        check_log("t3_b0", base + 0, 8'h0D, 1'b1);
        check_log("t3_b1", base + 1, 8'h11, 1'b1);
        check_log("t3_b2", base + 2, 8'h22, 1'b1);
        check_log("t3_b3", base + 3, 8'h33, 1'b1);
        check_log("t3_b4", base + 4, 8'h0D, 1'b0);

        // Round robin among three sources from a fresh reset
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        base = lg_n;
        push_pkt(0, 8'h05, 8'hA0, 8'h01);
        push_pkt(0, 8'h09, 8'hA1, 8'h01);
        push_pkt(1, 8'h06, 8'hB0, 8'h01);
        push_pkt(2, 8'h04, 8'hC0, 8'h01);
        wait_quiet("t2_quiet");
        check_eq("t2_count", 32'(lg_n - base), 32'd13);
        for (int k = 0; k < 13; k++)
            check_log($sformatf("t2_b%0d", k), base + k, t2_din[k], t2_pv[k]);
        check_eq("t2_gnt_hdr0", 32'(lg_grant[base + 0]), 32'h1);
        check_eq("t2_gnt_hdr1", 32'(lg_grant[base + 3]), 32'h2);
        check_eq("t2_gnt_hdr2", 32'(lg_grant[base + 6]), 32'h4);
        check_eq("t2_gnt_hdr3", 32'(lg_grant[base + 9]), 32'h1);
        check_eq("t2_gap0", 32'(lg_cyc[base + 3] - lg_cyc[base + 2] - 1), 32'd5);
        check_eq("t2_gap1", 32'(lg_cyc[base + 6] - lg_cyc[base + 5] - 1), 32'd5);
        check_eq("t2_gap2", 32'(lg_cyc[base + 9] - lg_cyc[base + 8] - 1), 32'd5);

        // Dest-3 packet from source 1 is drained; source 2 follows after the gap
        base = lg_n;
        h0 = hs_cnt[1];
        d0 = drop_cnt;
        push_pkt(1, 8'h03, 8'h00, 8'h00);
        push_pkt(2, 8'h04, 8'hC5, 8'h01);
        for (int c = 0; c < 8; c++) begin
            cycle();
            check_eq($sformatf("t4_out[%0d]", c), 32'({s_din, s_pv}), 32'd0);
            check_eq($sformatf("t4_gnt[%0d]", c), 32'(s_grant), 32'(t4_gnt[c]));
            check_eq($sformatf("t4_rdy[%0d]", c), 32'(s_ready), 32'(t4_rdy[c]));
            check_eq($sformatf("t4_drop[%0d]", c), 32'(s_drop), 32'(t4_drop[c]));
        end
        wait_quiet("t4_quiet");
        check_eq("t4_src1_hs", 32'(hs_cnt[1] - h0), 32'd2);
        check_eq("t4_drop_cnt", 32'(drop_cnt - d0), 32'd1);
        check_eq("t4_count", 32'(lg_n - base), 32'd3);
        check_log("t4_b0", base + 0, 8'h04, 1'b1);
        check_log("t4_b1", base + 1, 8'hC5, 1'b1);
        check_log("t4_b2", base + 2, 8'hC1, 1'b0);

        // L=0 packet from source 3, then an L=63 packet from source 0
        base = lg_n;
        push_pkt(3, 8'h02, 8'h00, 8'h00);
        push_pkt(0, 8'hFE, 8'h01, 8'h01);
        wait_quiet("t5_quiet");
        check_eq("t5_count", 32'(lg_n - base), 32'd67);
        check_log("t5_l0_hdr", base + 0, 8'h02, 1'b1);
        check_log("t5_l0_par", base + 1, 8'h02, 1'b0);
        check_eq("t5_l0_adj", 32'(lg_cyc[base + 1] - lg_cyc[base + 0]), 32'd1);
        check_eq("t5_l0_gnt", 32'(lg_grant[base + 0]), 32'h8);
        check_log("t5_l63_hdr", base + 2, 8'hFE, 1'b1);
        check_eq("t5_l63_gnt", 32'(lg_grant[base + 2]), 32'h1);
        bad = 0;
        for (int k = 1; k <= 63; k++)
            if (lg_din[base + 2 + k] !== 8'(k) || lg_pv[base + 2 + k] !== 1'b1) bad++;
        check_eq("t5_l63_payload_bad", 32'(bad), 32'd0);
        check_log("t5_l63_par", base + 66, 8'hFE, 1'b0);

        // Reset in the middle of a packet
        h0 = hs_cnt[1];
        push_pkt(1, 8'h11, 8'h01, 8'h01);
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            cycle();
            if (hs_cnt[1] - h0 == 3) found = 1'b1;
        end
        check_eq("t6_sync", 32'(found), 32'd1);
        reset = 1'b1;
        clear_queues();
        cycle();
        check_eq("t6_pre_din", 32'(s_din), 32'h02);
        check_eq("t6_pre_pv", 32'(s_pv), 32'd1);
        reset = 1'b0;
        base = lg_n;
        push_pkt(0, 8'h05, 8'hA0, 8'h01);
        push_pkt(1, 8'h06, 8'hB0, 8'h01);
        cycle();
        check_eq("t6_rst_grant", 32'(s_grant), 32'd0);
        check_eq("t6_rst_pv", 32'(s_pv), 32'd0);
        check_eq("t6_rst_din", 32'(s_din), 32'd0);
        check_eq("t6_rst_ready", 32'(s_ready), 32'd0);
        cycle();
        check_eq("t6_first_grant", 32'(s_grant), 32'h1);
        wait_quiet("t6_quiet");
        check_eq("t6_count", 32'(lg_n - base), 32'd6);
        check_log("t6_hdr0", base + 0, 8'h05, 1'b1);
        check_eq("t6_gnt0", 32'(lg_grant[base + 0]), 32'h1);
        check_log("t6_hdr1", base + 3, 8'h06, 1'b1);
        check_eq("t6_gnt1", 32'(lg_grant[base + 3]), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/router_ingress_arb.md
Name: router_ingress_arb

Overview:
- Round-robin arbiter that shares the router's single byte-wide input port (din/pkt_valid) among N_SRC packet sources.
- Grants one source for a whole packet: header, payload, then parity.
- Throttles the granted source against the router's busy, and enforces an inter-packet gap.
- Sits directly in front of the router top; drops packets addressed to the invalid destination 2'b11.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- GAP_CYCLES, 2, minimum idle cycles on din between the parity byte and the next header (1..15).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  N_SRC  source i holds a byte on its din slice.
- src_din  in  8*N_SRC  source i byte at bits [8i+7:8i].
- src_ready  out  N_SRC  byte from source i consumed this cycle when src_valid[i] & src_ready[i].
- grant  out  N_SRC  one-hot owner of the current packet; all zero when idle.
- busy  in  1  router busy; the byte on din is accepted only in cycles with busy low.
- pkt_valid  out  1  to router; high for header and payload bytes.
- din  out  8  to router data input.
- drop  out  1  one-cycle pulse when a dest-3 packet finishes draining.

Behaviour:
- Reset values: grant=0, src_ready=0, pkt_valid=0, din=0, drop=0, state=IDLE, rr pointer=N_SRC-1 (so source 0 has top priority first), gap counter=0, output stage empty.
- Packet format on each source: header byte (din[1:0]=dest, din[7:2]=payload length L, 0..63), then L payload bytes, then 1 parity byte.
- The arbiter counts L itself; there is no end marker from sources.

Output stage:
- One register holding din and pkt_valid, plus an occupied flag occ.
- The router consumes the byte when occ & !busy.
- src_ready[i] = grant[i] & state in {HDR, PAY, PAR} & (!occ | !busy).
- Each src handshake loads the register on the next edge: din = byte, pkt_valid = 1 for HDR/PAY and 0 for PAR.
- When occ=0, din=0 and pkt_valid=0.
- While occ & busy: din and pkt_valid hold stable and src_ready=0.

States:
- IDLE: if gap counter=0 and any src_valid, grant the first requester after the rr pointer (wrapping) and update the pointer to it. Next state is HDR. Grant is registered, so the first src_ready comes one cycle after the grant.
- HDR: on handshake, capture L into a 6-bit down counter.
  - dest!=3: go to PAY, or to PAR if L=0.
  - dest=3: go to DRAIN; the header is not loaded into the output stage.
- PAY: each handshake decrements the counter; the handshake with counter=1 goes to PAR.
- PAR: on handshake, go to GAP.
- DRAIN: src_ready[granted]=1 regardless of busy; no output-stage load. Consumes L payload bytes plus parity, then pulses drop for one cycle and goes to GAP.
- GAP: wait until occ=0 (parity accepted by router) and busy=0. Then clear grant, load the gap counter with GAP_CYCLES, and go to IDLE. The gap counter decrements to 0 in IDLE.

Rules and boundary conditions:
- Counter widths are exact: 6-bit length, 4-bit gap. A counter never wraps below 0.
- src_valid low mid-packet: the arbiter waits indefinitely; grant is held; no bubble byte is forwarded.
- Requests from non-granted sources are ignored until IDLE. Simultaneous requests are served in round-robin order.
- A single requesting source is re-granted after each gap.
- Reset asserted mid-packet: all state and outputs return to reset values on that edge; the partial packet is abandoned.

Test Plan:
1. Single source 0, header 8'h0D (dest 1, L=3), payload 11/22/33, parity P, busy=0 -> din shows 0D,11,22,33 with pkt_valid=1, then P with pkt_valid=0; grant=4'b0001 throughout; then ≥2 idle cycles.
2. Sources 0,1,2 all requesting continuously -> headers appear in order src0, src1, src2, src0. Each packet is complete before the next header, separated by ≥GAP_CYCLES idle cycles.
3. busy high for 3 cycles while payload byte 22 is on din -> din=22 held 3 cycles; src_ready=0; no byte lost or duplicated; stream resumes with 33.
4. Header 8'h03 (dest 3, L=0) then parity -> 2 source handshakes; din/pkt_valid stay 0; drop pulses exactly one cycle; next source granted after the gap.
5. L=0 header 8'h02 -> din shows header (pkt_valid=1) followed immediately by parity (pkt_valid=0); L=63 packet -> exactly 65 bytes forwarded.
6. reset asserted after the 2nd payload byte -> next cycle grant=0, pkt_valid=0, din=0; after release, source 0 is granted first.
